// File: rtl/ibus_responder_pkg.sv
// Shared instruction-bus types: fetch request, responder reply and the
// responder state encoding reused by the icache front end.
package ibus_responder_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 4;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic              addr_ok;
        logic              data_ok;
        logic [WORD_W-1:0] data;
    } ibus_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } ibus_resp_state_t;

endpackage

// File: rtl/ibus_responder_imem_array.sv
// Instruction word store: one write port, one read port whose result is
// registered at capture and reads as zero in every other cycle.
module ibus_responder_imem_array
    import ibus_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_idx_i,
    input  logic [WORD_W-1:0]        wr_data_i,
    input  logic                     rd_en_i,
    input  logic                     rd_zero_i,
    input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
    output logic [WORD_W-1:0]        rd_data_q
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rd_data_d;
    logic              bypass;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    // A write landing on the word being captured wins over the stored value.
    always_comb begin
        bypass    = wr_en_i && (wr_idx_i == rd_idx_i);
        rd_data_d = '0;
        if (rd_en_i && !rd_zero_i) begin
            rd_data_d = bypass ? wr_data_i : mem_q[rd_idx_i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

endmodule

// File: rtl/ibus_responder.sv
// Instruction-bus responder: latches a fetch request, waits LATENCY cycles,
// then returns one instruction word from the internal array.
module ibus_responder
    import ibus_responder_pkg::*;
#(
    parameter int unsigned     DEPTH   = 4096,
    parameter logic [XLEN-1:0] BASE    = 64'h8000_0000,
    parameter int unsigned     LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  ibus_req_t                ireq,
    output ibus_resp_t               iresp,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_idx,
    input  logic [WORD_W-1:0]        ld_data,
    output logic [31:0]              resp_count,
    output logic                     proto_err,
    output logic                     misalign_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    ibus_resp_state_t  state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   req_addr_q;
    logic              resp_q;
    logic [31:0]       resp_count_q;
    logic              proto_err_q;
    logic              misalign_err_q;

    logic [XLEN-1:0]   cap_addr;
    logic [XLEN-1:0]   cap_off;
    logic [IDX_W-1:0]  cap_idx;
    logic              cap_ok;
    logic              cap_en;
    logic [WORD_W-1:0] rd_data;

    // With zero latency the capture happens in IDLE, before req_addr is latched.
    always_comb begin
        cap_addr = (state_q == IDLE) ? ireq.addr : req_addr_q;
        cap_off  = cap_addr - BASE;
        cap_idx  = cap_off[IDX_W+1:2];
        cap_ok   = (cap_addr >= BASE)
                && ((cap_off >> 2) < XLEN'(DEPTH))
                && (cap_addr[1:0] == 2'b00);
        cap_en   = 1'b0;
        case (state_q)
            IDLE:    cap_en = ireq.valid && (LATENCY == 0);
            WAIT:    cap_en = ireq.valid && (cnt_q == '0);
            default: cap_en = 1'b0;
        endcase
    end

    ibus_responder_imem_array #(
        .DEPTH (DEPTH)
    ) u_imem (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (ld_en),
        .wr_idx_i  (ld_idx),
        .wr_data_i (ld_data),
        .rd_en_i   (cap_en),
        .rd_zero_i (!cap_ok),
        .rd_idx_i  (cap_idx),
        .rd_data_q (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            req_addr_q     <= '0;
            resp_q         <= 1'b0;
            resp_count_q   <= '0;
            proto_err_q    <= 1'b0;
            misalign_err_q <= 1'b0;
        end else begin
            resp_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ireq.valid) begin
                        req_addr_q <= ireq.addr;
                        if (ireq.addr[1:0] != 2'b00) begin
                            misalign_err_q <= 1'b1;
                        end
                        if (LATENCY == 0) begin
                            state_q <= RESP;
                            resp_q  <= 1'b1;
                        end else begin
                            cnt_q   <= CNT_W'(LATENCY - 1);
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!ireq.valid) begin
                        state_q <= IDLE;
                    end else if (cnt_q == '0) begin
                        state_q <= RESP;
                        resp_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    state_q      <= IDLE;
                    resp_count_q <= resp_count_q + 32'd1;
                end
                default: state_q <= IDLE;
            endcase
            // The in-flight request keeps using req_addr_q; only flag the violation.
            if ((state_q == WAIT || state_q == RESP) && ireq.valid
                && (ireq.addr != req_addr_q)) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    assign iresp        = '{addr_ok: resp_q, data_ok: resp_q, data: rd_data};
    assign resp_count   = resp_count_q;
    assign proto_err    = proto_err_q;
    assign misalign_err = misalign_err_q;

    a_single_cycle_resp: assert property (@(posedge clk) disable iff (reset)
        iresp.data_ok |=> !iresp.data_ok);
    a_data_only_with_ok: assert property (@(posedge clk) disable iff (reset)
        !iresp.data_ok |-> (iresp.data == '0));

endmodule

// File: tb/tb_ibus_responder.sv
// Directed bench for ibus_responder: one instance at LATENCY=2, one at LATENCY=0.
module tb_ibus_responder;
    import ibus_responder_pkg::*;

    logic        clk;
    logic        reset;
    logic        ld_en;
    logic [11:0] ld_idx;
    logic [31:0] ld_data;

    ibus_req_t   ireq2, ireq0;
    ibus_resp_t  iresp2, iresp0;
    logic [31:0] cnt2, cnt0;
    logic        perr2, perr0, merr2, merr0;

    int n_tests = 0;
    int n_fail  = 0;

    ibus_responder #(.DEPTH(4096), .BASE(64'h8000_0000), .LATENCY(2)) u_dut2 (
        .clk          (clk),
        .reset        (reset),
        .ireq         (ireq2),
        .iresp        (iresp2),
        .ld_en        (ld_en),
        .ld_idx       (ld_idx),
        .ld_data      (ld_data),
        .resp_count   (cnt2),
        .proto_err    (perr2),
        .misalign_err (merr2)
    );

    ibus_responder #(.DEPTH(4096), .BASE(64'h8000_0000), .LATENCY(0)) u_dut0 (
        .clk          (clk),
        .reset        (reset),
        .ireq         (ireq0),
        .iresp        (iresp0),
        .ld_en        (ld_en),
        .ld_idx       (ld_idx),
        .ld_data      (ld_data),
        .resp_count   (cnt0),
        .proto_err    (perr0),
        .misalign_err (merr0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [11:0] idx, input logic [31:0] data);
        ld_en   = 1'b1;
        ld_idx  = idx;
        ld_data = data;
        next_cycle();
        ld_en   = 1'b0;
    endtask

    // Waits (bounded) for data_ok on the LATENCY=2 instance; lat = -1 on timeout.
    task automatic wait_dok2(output logic [31:0] d, output int lat);
        lat = -1;
        d   = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (iresp2.data_ok) begin
                d   = iresp2.data;
                lat = k;
                next_cycle();
                break;
            end
            next_cycle();
        end
    endtask

    task automatic do_req2(input logic [63:0] a, output logic [31:0] d, output int lat);
        ireq2 = '{valid: 1'b1, addr: a};
        wait_dok2(d, lat);
        ireq2 = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int          lat;
        int          dok_seen;

        reset = 1'b1;
        ireq2 = '0;
        ireq0 = '0;
        ld_en = 1'b0;
        ld_idx = '0;
        ld_data = '0;
        repeat (3) next_cycle();
        @(negedge clk);
        check("rst_iresp2", 64'(iresp2), 64'h0);
        check("rst_cnt2", 64'(cnt2), 64'h0);
        check("rst_errs2", 64'({perr2, merr2}), 64'h0);
        next_cycle();
        reset = 1'b0;

        load(12'd0, 32'h0000_0013);
        load(12'd1, 32'h0010_0093);

        // LATENCY=2: request at cycle 0 answers in cycle 3 only
        ireq2 = '{valid: 1'b1, addr: 64'h8000_0004};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("l2_data_ok", 64'(iresp2.data_ok), 64'(k == 3));
            check("l2_addr_ok", 64'(iresp2.addr_ok), 64'(k == 3));
            check("l2_data", 64'(iresp2.data), (k == 3) ? 64'h0010_0093 : 64'h0);
            if (k == 4) check("l2_count", 64'(cnt2), 64'd1);
            next_cycle();
            if (k == 3) ireq2 = '0;
        end

        // LATENCY=0: back-to-back with address stepped after each data_ok
        ireq0 = '{valid: 1'b1, addr: 64'h8000_0000};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("l0_data_ok", 64'(iresp0.data_ok), 64'(k == 1 || k == 3));
            check("l0_data", 64'(iresp0.data),
                  (k == 1) ? 64'h13 : ((k == 3) ? 64'h0010_0093 : 64'h0));
            next_cycle();
            if (k == 1) ireq0.addr = 64'h8000_0004;
            if (k == 3) ireq0 = '0;
        end
        @(negedge clk);
        check("l0_count", 64'(cnt0), 64'd2);
        check("l0_errs", 64'({perr0, merr0}), 64'h0);
        next_cycle();

        // Bounds: below BASE, past the last word, then misaligned
        do_req2(64'h0000_1000, d, lat);
        check("oob_lo_data", 64'(d), 64'h0);
        check("oob_lo_lat", 64'(lat), 64'd3);
        do_req2(64'h8000_4000, d, lat);
        check("oob_hi_data", 64'(d), 64'h0);
        @(negedge clk);
        check("oob_no_merr", 64'(merr2), 64'h0);
        next_cycle();
        do_req2(64'h8000_0002, d, lat);
        check("mis_data", 64'(d), 64'h0);
        @(negedge clk);
        check("mis_merr", 64'(merr2), 64'h1);
        check("mis_count", 64'(cnt2), 64'd4);
        check("mis_no_perr", 64'(perr2), 64'h0);
        next_cycle();

        // Address changes during WAIT: flagged, old address still served
        ireq2 = '{valid: 1'b1, addr: 64'h8000_0000};
        next_cycle();
        ireq2.addr = 64'h8000_0004;
        wait_dok2(d, lat);
        ireq2 = '0;
        check("proto_data", 64'(d), 64'h13);
        check("proto_lat", 64'(lat), 64'd2);
        @(negedge clk);
        check("proto_err", 64'(perr2), 64'h1);
        next_cycle();

        // Valid dropped during WAIT: no response, count unchanged
        ireq2 = '{valid: 1'b1, addr: 64'h8000_0004};
        next_cycle();
        next_cycle();
        ireq2 = '0;
        dok_seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (iresp2.data_ok) dok_seen++;
            next_cycle();
        end
        check("drop_no_dok", 64'(dok_seen), 64'd0);
        check("drop_count", 64'(cnt2), 64'd5);
        do_req2(64'h8000_0004, d, lat);
        check("after_drop_data", 64'(d), 64'h0010_0093);
        check("after_drop_lat", 64'(lat), 64'd3);

        // Loader write to the captured word in the capture cycle
        ireq2 = '{valid: 1'b1, addr: 64'h8000_0004};
        next_cycle();
        next_cycle();
        ld_en   = 1'b1;
        ld_idx  = 12'd1;
        ld_data = 32'hDEAD_BEEF;
        next_cycle();
        ld_en   = 1'b0;
        @(negedge clk);
        check("byp_data_ok", 64'(iresp2.data_ok), 64'h1);
        check("byp_data", 64'(iresp2.data), 64'hDEAD_BEEF);
        next_cycle();
        ireq2 = '0;
        do_req2(64'h8000_0004, d, lat);
        check("byp_stored", 64'(d), 64'hDEAD_BEEF);
        @(negedge clk);
        check("byp_count", 64'(cnt2), 64'd8);
        next_cycle();

        // Reset while in WAIT: everything clears, request vanishes
        ireq2 = '{valid: 1'b1, addr: 64'h8000_0000};
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        ireq2 = '0;
        @(negedge clk);
        check("rst_wait_iresp", 64'(iresp2), 64'h0);
        check("rst_wait_count", 64'(cnt2), 64'h0);
        check("rst_wait_errs", 64'({perr2, merr2}), 64'h0);
        check("rst_wait_cnt0", 64'(cnt0), 64'h0);
        next_cycle();
        dok_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (iresp2.data_ok) dok_seen++;
            next_cycle();
        end
        check("rst_no_stray", 64'(dok_seen), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ibus_responder.md
Name: ibus_responder

Overview:
- Responder end of the instruction bus. It accepts the fetch stage's ibus_req_t and returns ibus_resp_t with a 32-bit instruction word.
- Backing store is an internal word array with configurable access latency.
- A loader port fills the array.
- Used as the instruction-memory model for pipeline simulation, and as the template for the later icache front end.

Parameters:
- DEPTH, 4096: number of 32-bit instruction words in the array (power of two).
- BASE, 64'h8000_0000: byte address of word 0.
- LATENCY, 2: wait cycles between request acceptance and response (0..15).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ireq  in  ibus_req_t  request from fetch: valid, addr (u64)
- iresp  out  ibus_resp_t  response: addr_ok, data_ok, data (u32)
- ld_en  in  1  loader write enable
- ld_idx  in  $clog2(DEPTH)  loader word index
- ld_data  in  32  loader write data
- resp_count  out  32  number of completed responses, wraps at 2^32
- proto_err  out  1  sticky: address changed while a request was pending
- misalign_err  out  1  sticky: accepted request had addr[1:0] != 0

Behaviour:
- Protocol:
  - The requester holds ireq.valid and ireq.addr stable until it sees data_ok.
  - addr_ok and data_ok are always asserted together, for exactly one cycle.
  - iresp.data is valid only while data_ok=1 and is 0 otherwise.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If ireq.valid, latch addr into req_addr.
  - If LATENCY==0, go to RESP; otherwise load cnt=LATENCY-1 and go to WAIT.
- WAIT:
  - If ireq.valid=0, go to IDLE (request abandoned, no response).
  - Else if cnt==0, go to RESP; else cnt--.
- Data capture and bounds:
  - Read data is registered on the transition into RESP.
  - Word index = (req_addr-BASE)>>2.
  - If req_addr < BASE or the index >= DEPTH, the data is 32'h0.
  - If misaligned, the data is 32'h0 and misalign_err is set.
- RESP:
  - Drive addr_ok=data_ok=1 with the registered data, and increment resp_count.
  - Next state is IDLE unconditionally. The following request is accepted at the earliest one cycle later, in IDLE.
  - If ireq.valid=0 in RESP, still respond (the requester drops it) and still count it.
- Latency: request first seen valid in IDLE at cycle t gives data_ok in cycle t+LATENCY+1. Throughput is one response per LATENCY+2 cycles.
- proto_err: set if, in WAIT or RESP with ireq.valid=1, ireq.addr != req_addr. The in-flight request still completes using the latched req_addr.
- Loader:
  - Writes the array at the clock edge when ld_en=1, in any state.
  - If the write targets the index being captured into RESP in the same cycle, the new ld_data is returned (write-first bypass).
- Reset:
  - Effects: state=IDLE, cnt=0, req_addr=0, resp_count=0, proto_err=0, misalign_err=0, iresp all zero. Array contents are not reset.
  - Reset mid-request drops that request silently; no data_ok is produced afterwards.

Decomposition:
- ibus_req_t and ibus_resp_t come from the shared common package, unchanged.
- Add the state enum ibus_resp_state_t (IDLE, WAIT, RESP) to the common package for reuse by the future icache.
- Natural sub-module: imem_array. Single read port with registered capture, one write port, write-first bypass.
- The FSM and counters stay in ibus_responder.

Test Plan:
- Load word 0 = 32'h0000_0013 and word 1 = 32'h0010_0093; with LATENCY=2, hold valid with addr=64'h8000_0004 from cycle 10 -> data_ok and addr_ok=1 in cycle 13 only, data=32'h0010_0093, resp_count=1.
- With LATENCY=0, keep valid high and step the address 0x8000_0000, then 0x8000_0004 after each data_ok -> responses at t+1 and t+3, data 0x13 then 0x0010_0093.
- Out-of-range addr=64'h0000_1000, and separately misaligned addr=64'h8000_0002 -> data=0; misalign_err=1 only after the misaligned case.
- Change addr from 0x8000_0000 to 0x8000_0004 during WAIT -> proto_err=1, and the response carries word 0 data.
- Drop valid during WAIT -> no data_ok, FSM back in IDLE, resp_count unchanged. A new request afterwards completes normally.
- Assert reset in WAIT -> all outputs 0 the next cycle, no stray data_ok.
- Loader write to index 1 (value 32'hDEAD_BEEF) in the cycle of capture for addr 0x8000_0004 -> response data 32'hDEAD_BEEF.
